fetch_decode_controller: RTL

- Sequences instruction flow into the instruction decoder stage.
- Fetches 32-bit instruction words from instruction memory over a single-outstanding req/ack handshake and buffers them in a 2-entry prefetch queue.
- Feeds one instruction at a time to the decoder and drives its clock enable, so that microcode lookups stall, flush and redirect correctly.
- Sits between the instruction memory port and the decoder/microcode ROM, and is driven by execute-stage stall and redirect signals.

---
 rtl/fetch_decode_controller.sv | 131 +++++++++++++
 1 files changed

// File: rtl/fetch_decode_controller.sv
// Fetch sequencer: memory req/ack, 2-entry prefetch queue,
// and decoder enable/valid generation with stall and redirect.
module fetch_decode_controller #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instruction,
  output logic [31:0] pc_out,
  output logic        decode_enable,
  output logic        decode_valid
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_SPACE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [31:0] fetch_pc;
  logic [31:0] drop_pc;
  logic        drop;
  logic [1:0]  count;
  logic [1:0]  count_nx;
  logic [1:0]  wr_pos;
  logic [31:0] q_instr [2];
  logic [31:0] q_pc    [2];
  logic [31:0] tgt_pc;
  logic        in_req;
  logic        push;
  logic        pop;

  assign tgt_pc = redirect_pc & ~32'h3;
  assign in_req = (state == REQ);
  assign push   = in_req & mem_ack & ~drop & ~redirect;
  assign pop    = (count != 2'd0) & ~stall & ~redirect;
  assign wr_pos = count - {1'b0, pop};

  assign count_nx = redirect ? 2'd0
                  : count + {1'b0, push} - {1'b0, pop};

  // While a dropped request is pending the old address must stay on the bus
  assign mem_req  = in_req;
  assign mem_addr = drop ? drop_pc : fetch_pc;

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: state_nx = REQ;
      REQ: begin
        if (mem_ack)
          state_nx = (count_nx < 2'd2) ? REQ : WAIT_SPACE;
      end
      WAIT_SPACE: begin
        if (count_nx < 2'd2)
          state_nx = REQ;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      drop_pc  <= RESET_PC;
      drop     <= 1'b0;
      count    <= 2'd0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      if (redirect)
        fetch_pc <= tgt_pc;
      else if (push)
        fetch_pc <= fetch_pc + 32'd4;
      if (in_req) begin
        if (mem_ack)
          drop <= 1'b0;
        else if (redirect)
          drop <= 1'b1;
      end
      if (in_req & ~mem_ack & redirect & ~drop)
        drop_pc <= fetch_pc;
    end
  end

  // Head lives in slot 0; a pop shifts, a push lands behind the survivors
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_instr[0] <= 32'h0;
      q_instr[1] <= 32'h0;
      q_pc[0]    <= 32'h0;
      q_pc[1]    <= 32'h0;
    end else begin
      if (pop) begin
        q_instr[0] <= q_instr[1];
        q_pc[0]    <= q_pc[1];
      end
      if (push) begin
        q_instr[wr_pos[0]] <= mem_rdata;
        q_pc[wr_pos[0]]    <= mem_addr;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instruction   <= 32'h0;
      pc_out        <= 32'h0;
      decode_enable <= 1'b0;
      decode_valid  <= 1'b0;
    end else begin
      decode_enable <= pop;
      decode_valid  <= decode_enable & ~redirect;
      if (pop) begin
        instruction <= q_instr[0];
        pc_out      <= q_pc[0];
      end
    end
  end

endmodule
